// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter.
// Optional feature macro: ARB_STARVE_GUARD_EN (ifetch starvation guard).
package mem_arbiter_pkg;

    localparam int ADDR_WIDTH   = 32;
    localparam int VAL_WIDTH    = 32;
    localparam int LSB_ID_WIDTH = 4;
    localparam int FUNCT3_WIDTH = 3;

    // Request / grant vector bit positions
    localparam int NUM_REQ = 3;
    localparam int GNT_ST  = 0;
    localparam int GNT_LD  = 1;
    localparam int GNT_IF  = 2;

    // Address bits [17:16] equal to this value select the IO space
    localparam logic [1:0] IO_SPACE = 2'b11;

    // Instruction fetches are always full-word loads
    localparam logic [FUNCT3_WIDTH-1:0] IF_FUNCT3 = 3'b010;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LSB_WAIT = 2'd1,
        IF_WAIT  = 2'd2,
        IF_DRAIN = 2'd3
    } arb_state_t;

    // True for a store that targets the IO space
    function automatic logic is_io_store(input logic wr, input logic [1:0] region);
        return wr && (region == IO_SPACE);
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational priority picker: store > load > ifetch, with an
// optional starvation override that lets a waiting ifetch win.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               io_block,
    input  logic               flush,
    input  logic               starve,
    output logic [NUM_REQ-1:0] grant
);

    // One-hot winner selection; flush only suppresses the ifetch request
    always_comb begin
        grant = '0;
        if (req[GNT_IF] && !flush && starve) begin
            grant[GNT_IF] = 1'b1;
        end else if (req[GNT_ST] && !io_block) begin
            grant[GNT_ST] = 1'b1;
        end else if (req[GNT_LD]) begin
            grant[GNT_LD] = 1'b1;
        end else if (req[GNT_IF] && !flush) begin
            grant[GNT_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared byte-serial memory engine between the icache
// (ifetch) and the load/store buffer. Optional macro ARB_STARVE_GUARD_EN
// adds a counter that forces an ifetch grant after STARVE_LIMIT
// consecutive LSB grants made while an ifetch was waiting.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush,
    input  logic                    io_buffer_full,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_ack,
    output logic [VAL_WIDTH-1:0]    if_inst,
    input  logic                    lsb_req,
    input  logic                    lsb_wr,
    input  logic [ADDR_WIDTH-1:0]   lsb_addr,
    input  logic [VAL_WIDTH-1:0]    lsb_wdata,
    input  logic [FUNCT3_WIDTH-1:0] lsb_type,
    input  logic [LSB_ID_WIDTH-1:0] lsb_id,
    output logic                    lsb_ack,
    output logic [VAL_WIDTH-1:0]    lsb_rdata,
    output logic [LSB_ID_WIDTH-1:0] lsb_rid,
    output logic                    eng_start,
    output logic                    eng_wr,
    output logic [ADDR_WIDTH-1:0]   eng_addr,
    output logic [VAL_WIDTH-1:0]    eng_wdata,
    output logic [FUNCT3_WIDTH-1:0] eng_type,
    input  logic                    eng_done,
    input  logic [VAL_WIDTH-1:0]    eng_rdata,
    output logic                    arb_busy
);

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    arb_state_t              state;
    logic [LSB_ID_WIDTH-1:0] lat_id;
    logic [NUM_REQ-1:0]      req_vec;
    logic [NUM_REQ-1:0]      grant;
    logic                    can_grant;
    logic                    io_block;
    logic                    starve;

    // Requesters hold their request through the ack cycle, so the ack
    // cycle itself must not grant or the finished access would repeat.
    assign can_grant = (state == IDLE) && !lsb_ack && !if_ack;
    assign io_block  = io_buffer_full && is_io_store(lsb_wr, lsb_addr[17:16]);
    assign req_vec   = {can_grant & if_req,
                        can_grant & lsb_req & ~lsb_wr,
                        can_grant & lsb_req & lsb_wr};
    assign arb_busy  = (state != IDLE);

    arb_pick u_pick (
        .req      (req_vec),
        .io_block (io_block),
        .flush    (flush),
        .starve   (starve),
        .grant    (grant)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    assign starve = (starve_cnt == CNT_MAX);

    // Count LSB grants that overtook a waiting ifetch, saturating at the limit
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            starve_cnt <= '0;
        end else if (rdy_in) begin
            if (!if_req || grant[GNT_IF]) begin
                starve_cnt <= '0;
            end else if ((grant[GNT_ST] || grant[GNT_LD]) && (starve_cnt != CNT_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    assign starve = 1'b0;
`endif

    // Main FSM: issue the engine command on a grant, then turn eng_done
    // into a one-cycle ack for whichever requester owns the access
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            eng_start <= 1'b0;
            eng_wr    <= 1'b0;
            eng_addr  <= '0;
            eng_wdata <= '0;
            eng_type  <= '0;
            if_ack    <= 1'b0;
            if_inst   <= '0;
            lsb_ack   <= 1'b0;
            lsb_rdata <= '0;
            lsb_rid   <= '0;
            lat_id    <= '0;
        end else if (rdy_in) begin
            eng_start <= 1'b0;
            if_ack    <= 1'b0;
            lsb_ack   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant[GNT_ST] || grant[GNT_LD]) begin
                        eng_start <= 1'b1;
                        eng_wr    <= lsb_wr;
                        eng_addr  <= lsb_addr;
                        eng_wdata <= lsb_wdata;
                        eng_type  <= lsb_type;
                        lat_id    <= lsb_id;
                        state     <= LSB_WAIT;
                    end else if (grant[GNT_IF]) begin
                        eng_start <= 1'b1;
                        eng_wr    <= 1'b0;
                        eng_addr  <= if_addr;
                        eng_wdata <= '0;
                        eng_type  <= IF_FUNCT3;
                        state     <= IF_WAIT;
                    end
                end
                LSB_WAIT: begin
                    // Flush is deliberately ignored: committed stores must finish
                    if (eng_done) begin
                        lsb_ack   <= 1'b1;
                        lsb_rdata <= eng_wr ? '0 : eng_rdata;
                        lsb_rid   <= lat_id;
                        state     <= IDLE;
                    end
                end
                IF_WAIT: begin
                    if (eng_done) begin
                        if (!flush) begin
                            if_ack  <= 1'b1;
                            if_inst <= eng_rdata;
                        end
                        state <= IDLE;
                    end else if (flush) begin
                        state <= IF_DRAIN;
                    end
                end
                IF_DRAIN: begin
                    if (eng_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of single-grant vectors
// from IDLE plus hand-written multi-cycle sequences.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, flush, io_buffer_full;
    logic        if_req, if_ack;
    logic [31:0] if_addr, if_inst;
    logic        lsb_req, lsb_wr, lsb_ack;
    logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
    logic [2:0]  lsb_type;
    logic [3:0]  lsb_id, lsb_rid;
    logic        eng_start, eng_wr, eng_done, arb_busy;
    logic [31:0] eng_addr, eng_wdata, eng_rdata;
    logic [2:0]  eng_type;

    int assert_count = 0;
    int fail_count   = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_inst(if_inst),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
        .lsb_type(lsb_type), .lsb_id(lsb_id),
        .lsb_ack(lsb_ack), .lsb_rdata(lsb_rdata), .lsb_rid(lsb_rid),
        .eng_start(eng_start), .eng_wr(eng_wr), .eng_addr(eng_addr),
        .eng_wdata(eng_wdata), .eng_type(eng_type),
        .eng_done(eng_done), .eng_rdata(eng_rdata), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lsb_req;
        logic        lsb_wr;
        logic [31:0] lsb_addr;
        logic [31:0] lsb_wdata;
        logic [2:0]  lsb_type;
        logic [3:0]  lsb_id;
        logic        if_req;
        logic [31:0] if_addr;
        logic        flush;
        logic        io_full;
        logic        exp_start;
        logic        exp_wr;
        logic [31:0] exp_addr;
        logic [2:0]  exp_type;
        logic        exp_lsb_ack;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        lsb_req = v.lsb_req; lsb_wr = v.lsb_wr; lsb_addr = v.lsb_addr;
        lsb_wdata = v.lsb_wdata; lsb_type = v.lsb_type; lsb_id = v.lsb_id;
        if_req = v.if_req; if_addr = v.if_addr; flush = v.flush;
        io_buffer_full = v.io_full;
    endtask

    task automatic dropAll();
        lsb_req = 1'b0; if_req = 1'b0; flush = 1'b0; io_buffer_full = 1'b0;
        eng_done = 1'b0;
    endtask

    task automatic pulseDone(input logic [31:0] data);
        eng_done = 1'b1;
        eng_rdata = data;
        tick();
        eng_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lsb_grants, if_grants, starts, acks;

        // lsb_req wr addr wdata type id | if_req if_addr flush io_full |
        // exp_start exp_wr exp_addr exp_type exp_lsb_ack exp_rdata
        vecs[0] = '{1, 0, 32'h100,   32'h0,    3'b010, 4'd3, 0, 32'h0,    0, 0, 1, 0, 32'h100,   3'b010, 1, 32'hA5A50000};
        vecs[1] = '{1, 1, 32'h204,   32'hBEEF, 3'b000, 4'd5, 0, 32'h0,    0, 0, 1, 1, 32'h204,   3'b000, 1, 32'h0};
        vecs[2] = '{0, 0, 32'h0,     32'h0,    3'b000, 4'd0, 1, 32'h1000, 0, 0, 1, 0, 32'h1000,  3'b010, 0, 32'hA5A50002};
        vecs[3] = '{1, 0, 32'h300,   32'h0,    3'b100, 4'd6, 1, 32'h1004, 0, 0, 1, 0, 32'h300,   3'b100, 1, 32'hA5A50003};
        vecs[4] = '{1, 1, 32'h30000, 32'h41,   3'b001, 4'd1, 1, 32'h1008, 0, 1, 1, 0, 32'h1008,  3'b010, 0, 32'hA5A50004};
        vecs[5] = '{0, 0, 32'h0,     32'h0,    3'b000, 4'd0, 1, 32'h100C, 1, 0, 0, 0, 32'h0,     3'b000, 0, 32'h0};
        vecs[6] = '{1, 1, 32'h30000, 32'h42,   3'b000, 4'd2, 0, 32'h0,    0, 0, 1, 1, 32'h30000, 3'b000, 1, 32'h0};
        vecs[7] = '{1, 0, 32'h30004, 32'h0,    3'b100, 4'd9, 0, 32'h0,    0, 1, 1, 0, 32'h30004, 3'b100, 1, 32'hA5A50007};
        vecs[8] = '{1, 1, 32'h30008, 32'h43,   3'b000, 4'd4, 0, 32'h0,    0, 1, 0, 0, 32'h0,     3'b000, 0, 32'h0};
        vecs[9] = '{1, 0, 32'h400,   32'h0,    3'b010, 4'd8, 0, 32'h0,    1, 0, 1, 0, 32'h400,   3'b010, 1, 32'hA5A50009};

        rst_in = 1'b0; rdy_in = 1'b1; dropAll();
        if_addr = '0; lsb_wr = 0; lsb_addr = '0; lsb_wdata = '0; lsb_type = '0; lsb_id = '0;
        eng_rdata = '0;
        repeat (2) tick();
        checkOutput("reset_ctrl", {28'd0, eng_start, if_ack, lsb_ack, arb_busy}, 32'h0);
        checkOutput("reset_addr", eng_addr, 32'h0);
        rst_in = 1'b1;
        tick();

        // Table: one grant decision from a quiet IDLE state, then completion
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("v%0d_start", i), {31'd0, eng_start}, {31'd0, vecs[i].exp_start});
            if (vecs[i].exp_start) begin
                checkOutput($sformatf("v%0d_wr", i), {31'd0, eng_wr}, {31'd0, vecs[i].exp_wr});
                checkOutput($sformatf("v%0d_addr", i), eng_addr, vecs[i].exp_addr);
                checkOutput($sformatf("v%0d_type", i), {29'd0, eng_type}, {29'd0, vecs[i].exp_type});
                pulseDone(32'hA5A50000 + i);
                checkOutput($sformatf("v%0d_lsb_ack", i), {31'd0, lsb_ack}, {31'd0, vecs[i].exp_lsb_ack});
                checkOutput($sformatf("v%0d_if_ack", i), {31'd0, if_ack}, {31'd0, !vecs[i].exp_lsb_ack});
                if (vecs[i].exp_lsb_ack) begin
                    checkOutput($sformatf("v%0d_rdata", i), lsb_rdata, vecs[i].exp_rdata);
                    checkOutput($sformatf("v%0d_rid", i), {28'd0, lsb_rid}, {28'd0, vecs[i].lsb_id});
                end else begin
                    checkOutput($sformatf("v%0d_inst", i), if_inst, vecs[i].exp_rdata);
                end
            end
            dropAll();
            repeat (2) tick();
        end

        // Simultaneous load and ifetch: load first, ifetch after the ack cycle
        $display("[TB] simultaneous requests");
        lsb_req = 1; lsb_wr = 0; lsb_addr = 32'h100; lsb_type = 3'b010; lsb_id = 4'd3;
        if_req = 1; if_addr = 32'h2000;
        tick();
        checkOutput("sim_lsb_first", {eng_start, eng_addr[30:0]}, {1'b1, 31'h100});
        repeat (3) tick();
        pulseDone(32'h11112222);
        checkOutput("sim_lsb_ack", {lsb_ack, 3'd0, lsb_rid}, {1'b1, 3'd0, 4'd3});
        checkOutput("sim_lsb_rdata", lsb_rdata, 32'h11112222);
        checkOutput("sim_no_grant_in_ack", {31'd0, eng_start}, 32'd0);
        lsb_req = 0;
        tick();
        checkOutput("sim_ack_pulse_once", {31'd0, lsb_ack}, 32'd0);
        tick();
        checkOutput("sim_if_grant", {eng_start, eng_addr[30:0]}, {1'b1, 31'h2000});
        repeat (3) tick();
        pulseDone(32'h33334444);
        checkOutput("sim_if_ack", {31'd0, if_ack}, 32'd1);
        checkOutput("sim_if_inst", if_inst, 32'h33334444);
        if_req = 0;
        repeat (2) tick();

        // Continuous LSB traffic with an ifetch waiting
        $display("[TB] starvation guard");
        lsb_req = 1; lsb_wr = 0; lsb_addr = 32'h500; if_req = 1; if_addr = 32'h6000;
        lsb_grants = 0; if_grants = 0;
        for (int c = 0; c < 60 && if_grants == 0; c++) begin
            tick();
            eng_done = eng_start;
            eng_rdata = 32'h5;
            if (eng_start) begin
                if (eng_addr == 32'h6000) if_grants++;
                else lsb_grants++;
            end
        end
`ifdef ARB_STARVE_GUARD_EN
        checkOutput("starve_lsb_grants", lsb_grants, 32'd4);
        checkOutput("starve_if_grants", if_grants, 32'd1);
`else
        checkOutput("fixed_lsb_grants", lsb_grants, 32'd20);
        checkOutput("fixed_if_grants", if_grants, 32'd0);
`endif
        lsb_req = 0; if_req = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            eng_done = eng_start;
        end
        eng_done = 0;

        // IO-space store held off while the UART buffer is full
        $display("[TB] IO store block");
        lsb_req = 1; lsb_wr = 1; lsb_addr = 32'h30000; lsb_wdata = 32'h55; lsb_type = 3'b000;
        lsb_id = 4'd2; io_buffer_full = 1;
        starts = 0; acks = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (eng_start) starts++;
            if (lsb_ack) acks++;
        end
        checkOutput("io_blocked_starts", starts + acks, 32'd0);
        io_buffer_full = 0;
        tick();
        checkOutput("io_grant", {eng_start, eng_wr, eng_addr[29:0]}, {2'b11, 30'h30000});
        pulseDone(32'h9999);
        checkOutput("io_ack_rdata", {lsb_ack, lsb_rdata[30:0]}, {1'b1, 31'h0});
        lsb_req = 0;
        repeat (2) tick();

        // Flush during fetch: drain silently, then serve a store
        $display("[TB] flush during fetch");
        if_req = 1; if_addr = 32'h3000;
        tick();
        checkOutput("fl_if_grant", {31'd0, eng_start}, 32'd1);
        flush = 1;
        tick();
        flush = 0; if_req = 0;
        acks = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (if_ack || !arb_busy) acks++;
        end
        checkOutput("fl_drain_busy", acks, 32'd0);
        pulseDone(32'h12345678);
        checkOutput("fl_no_ack", {30'd0, if_ack, arb_busy}, 32'd0);
        lsb_req = 1; lsb_wr = 1; lsb_addr = 32'h600; lsb_id = 4'd2;
        tick();
        checkOutput("fl_store_grant", {eng_start, eng_wr, eng_addr[29:0]}, {2'b11, 30'h600});
        pulseDone(32'h1);
        checkOutput("fl_store_ack", {31'd0, lsb_ack}, 32'd1);
        lsb_req = 0;
        repeat (2) tick();

        // Flush and eng_done in the same IF_WAIT cycle discard the fetch
        if_req = 1; if_addr = 32'h3100;
        tick();
        flush = 1;
        pulseDone(32'hDEAD);
        checkOutput("fl_done_same_cycle", {30'd0, if_ack, arb_busy}, 32'd0);
        flush = 0; if_req = 0;
        repeat (2) tick();

        // Stall in IF_WAIT: everything frozen, including the start pulse
        $display("[TB] stall");
        if_req = 1; if_addr = 32'h4000;
        tick();
        rdy_in = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput($sformatf("stall_frozen_%0d", c), {eng_start, arb_busy, if_ack, eng_addr[28:0]},
                        {3'b110, 29'h4000});
        end
        rdy_in = 1;
        tick();
        checkOutput("stall_resume", {30'd0, eng_start, arb_busy}, 32'd1);
        pulseDone(32'hCAFE0001);
        checkOutput("stall_if_ack", {31'd0, if_ack}, 32'd1);
        checkOutput("stall_if_inst", if_inst, 32'hCAFE0001);
        if_req = 0;
        repeat (2) tick();

        // Asynchronous reset in the middle of LSB_WAIT
        $display("[TB] async reset");
        lsb_req = 1; lsb_wr = 0; lsb_addr = 32'h700; lsb_wdata = 32'h77; lsb_type = 3'b010; lsb_id = 4'd7;
        tick();
        tick();
        #3 rst_in = 0;
        #1;
        checkOutput("rst_ctrl", {27'd0, eng_start, eng_wr, if_ack, lsb_ack, arb_busy}, 32'd0);
        checkOutput("rst_eng_addr", eng_addr, 32'h0);
        checkOutput("rst_eng_type", {29'd0, eng_type}, 32'h0);
        checkOutput("rst_if_inst", if_inst, 32'h0);
        checkOutput("rst_lsb_rid", {28'd0, lsb_rid}, 32'h0);
        checkOutput("rst_lsb_rdata", lsb_rdata, 32'h0);
        eng_done = 1;
        tick();
        rst_in = 1;
        eng_done = 0;
        tick();
        checkOutput("rst_regrant_no_ack", {30'd0, eng_start, lsb_ack}, 32'd2);
        pulseDone(32'h7777);
        checkOutput("rst_after_ack", {lsb_ack, 3'd0, lsb_rid}, {1'b1, 3'd0, 4'd7});
        lsb_req = 0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
